// File: rtl/dsp_slice_simd_if.sv
// Operation/result bundle for the multi-lane DSP slice.
// The sticky saturation flag exists only when DSP_SLICE_SIMD_OVF_EN is defined.
interface dsp_slice_simd_if #(
   parameter int DWIDTH = 8,
   parameter int LANES  = 2
);
   logic                      in_valid;
   logic [1:0]                mode;
   logic                      acc_clear;
   logic                      carry_in;
   logic [LANES*DWIDTH-1:0]   ax;
   logic [LANES*DWIDTH-1:0]   ay;
   logic [LANES*DWIDTH-1:0]   az;
   logic                      out_valid;
   logic [LANES*DWIDTH-1:0]   result;
   logic [LANES-1:0]          carry_out;
`ifdef DSP_SLICE_SIMD_OVF_EN
   logic [LANES-1:0]          ovf;
`endif

   // Operation source
   modport master (
      output in_valid, mode, acc_clear, carry_in, ax, ay, az,
      input  out_valid, result, carry_out
`ifdef DSP_SLICE_SIMD_OVF_EN
      , ovf
`endif
   );

   // The slice itself
   modport slave (
      input  in_valid, mode, acc_clear, carry_in, ax, ay, az,
      output out_valid, result, carry_out
`ifdef DSP_SLICE_SIMD_OVF_EN
      , ovf
`endif
   );
endinterface

// File: rtl/dsp_slice_simd.sv
// LANES-wide signed DSP slice: ADD / MUL / MAC / MULADD, saturating product, 3-cycle latency.
// Optional sticky per-lane saturation flag enabled by defining DSP_SLICE_SIMD_OVF_EN.
module dsp_slice_simd #(
   parameter int DWIDTH = 8,
   parameter int LANES  = 2
) (
   input logic             clk,
   input logic             reset,
   dsp_slice_simd_if.slave bus
);

   localparam int PW = 2 * DWIDTH;
   localparam logic [DWIDTH-1:0] SAT_MAX = {1'b0, {(DWIDTH-1){1'b1}}};
   localparam logic [DWIDTH-1:0] SAT_MIN = {1'b1, {(DWIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      MODE_ADD    = 2'b00,
      MODE_MUL    = 2'b01,
      MODE_MAC    = 2'b10,
      MODE_MULADD = 2'b11
   } mode_e;

   typedef logic [LANES-1:0][DWIDTH-1:0] lane_vec_t;
   typedef logic [LANES-1:0][PW-1:0]     prod_vec_t;

   // ---------------- S1: operand capture ----------------
   logic      v1;
   mode_e     mode1;
   logic      clr1;
   logic      ci1;
   lane_vec_t ax1, ay1, az1;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         v1    <= 1'b0;
         mode1 <= MODE_ADD;
         clr1  <= 1'b0;
         ci1   <= 1'b0;
         ax1   <= '0;
         ay1   <= '0;
         az1   <= '0;
      end else begin
         v1 <= bus.in_valid;
         if (bus.in_valid) begin
            mode1 <= mode_e'(bus.mode);
            clr1  <= bus.acc_clear;
            ci1   <= bus.carry_in;
            ax1   <= bus.ax;
            ay1   <= bus.ay;
            az1   <= bus.az;
         end
      end
   end

   // ---------------- S2: full-width signed product ----------------
   prod_vec_t prod_c;

   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      prod_c = '0;
      for (int i = 0; i < LANES; i++) begin
         prod_c[i] = $signed(ay1[i]) * $signed(az1[i]);
      end
   end

   logic      v2;
   mode_e     mode2;
   logic      clr2;
   logic      ci2;
   lane_vec_t ax2, ay2;
   prod_vec_t prod2;

   always_ff @(posedge clk) begin
      if (reset) begin
         v2    <= 1'b0;
         mode2 <= MODE_ADD;
         clr2  <= 1'b0;
         ci2   <= 1'b0;
         ax2   <= '0;
         ay2   <= '0;
         prod2 <= '0;
      end else begin
         v2 <= v1;
         if (v1) begin
            mode2 <= mode1;
            clr2  <= clr1;
            ci2   <= ci1;
            ax2   <= ax1;
            ay2   <= ay1;
            prod2 <= prod_c;
         end
      end
   end

   // ---------------- S3: down-cast, operand select, add ----------------
   lane_vec_t             result_q;
   logic [LANES-1:0]      carry_q;
   logic                  out_valid_q;

   lane_vec_t             sat_val;
   logic [LANES-1:0]      sat_hit;
   lane_vec_t             op_a, op_b;
   logic                  cin;
   logic [LANES-1:0][DWIDTH:0] sum;
   lane_vec_t             res_c;
   logic [LANES-1:0]      co_c;
   logic                  mac_clear;

   always_comb begin
      sat_val   = '0;
      sat_hit   = '0;
      op_a      = '0;
      op_b      = '0;
      sum       = '0;
      res_c     = '0;
      co_c      = '0;
      cin       = ci2;
      mac_clear = (mode2 == MODE_MAC) && clr2;

      for (int i = 0; i < LANES; i++) begin
         // Product fits when its top DWIDTH+1 bits are all copies of the sign.
         if ((&prod2[i][PW-1:DWIDTH-1]) || !(|prod2[i][PW-1:DWIDTH-1])) begin
            sat_val[i] = prod2[i][DWIDTH-1:0];
         end else begin
            sat_val[i] = prod2[i][PW-1] ? SAT_MIN : SAT_MAX;
            sat_hit[i] = (mode2 != MODE_ADD);
         end

         unique case (mode2)
            MODE_ADD: begin
               op_a[i] = ax2[i];
               op_b[i] = ay2[i];
            end
            MODE_MUL: begin
               op_a[i] = '0;
               op_b[i] = sat_val[i];
            end
            MODE_MAC: begin
               // The result register doubles as the accumulator.
               op_a[i] = clr2 ? '0 : result_q[i];
               op_b[i] = sat_val[i];
            end
            default: begin
               op_a[i] = ax2[i];
               op_b[i] = sat_val[i];
            end
         endcase

         sum[i] = {1'b0, op_a[i]} + {1'b0, op_b[i]}
                + {{DWIDTH{1'b0}}, (mode2 == MODE_MUL) ? 1'b0 : cin};
         res_c[i] = sum[i][DWIDTH-1:0];
         co_c[i]  = sum[i][DWIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         carry_q     <= '0;
      end else begin
         out_valid_q <= v2;
         if (v2) begin
            result_q <= res_c;
            carry_q  <= co_c;
         end
      end
   end

`ifdef DSP_SLICE_SIMD_OVF_EN
   logic [LANES-1:0] ovf_q;

   // A saturating op in the same MAC that clears the flag leaves it set.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= '0;
      end else if (v2) begin
         ovf_q <= (mac_clear ? '0 : ovf_q) | sat_hit;
      end
   end

   assign bus.ovf = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ^{sat_hit, mac_clear};
`endif

   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.carry_out = carry_q;

endmodule
